// File: rtl/clock_pkg.sv
// Shared calendar definitions: field/weekday encodings, month and Sakamoto tables,
// leap rule and weekday helpers used by the date counter.
package clock_pkg;

  localparam int unsigned DAY_W = 5;
  localparam int unsigned MON_W = 4;
  localparam int unsigned WD_W  = 3;

  typedef enum logic [1:0] {
    FIELD_DAY   = 2'd0,
    FIELD_MONTH = 2'd1,
    FIELD_YEAR  = 2'd2,
    FIELD_NONE  = 2'd3
  } edit_field_e;

  typedef enum logic [WD_W-1:0] {
    WD_SUN = 3'd0, WD_MON = 3'd1, WD_TUE = 3'd2, WD_WED = 3'd3,
    WD_THU = 3'd4, WD_FRI = 3'd5, WD_SAT = 3'd6
  } weekday_e;

  function automatic logic is_leap(input logic [15:0] year);
    return ((year % 16'd4) == 16'd0) &&
           (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));
  endfunction

  // Length of a month; zero for an out-of-range month so range checks fail cleanly
  function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] month, input logic leap);
    logic [DAY_W-1:0] len;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
      4'd2:                                       len = leap ? 5'd29 : 5'd28;
      default:                                    len = 5'd0;
    endcase
    return len;
  endfunction

  function automatic logic [2:0] sakamoto_off(input logic [MON_W-1:0] month);
    logic [2:0] off;
    case (month)
      4'd1: off = 3'd0;  4'd2: off = 3'd3;  4'd3: off = 3'd2;  4'd4: off = 3'd5;
      4'd5: off = 3'd0;  4'd6: off = 3'd3;  4'd7: off = 3'd5;  4'd8: off = 3'd1;
      4'd9: off = 3'd4;  4'd10: off = 3'd6; 4'd11: off = 3'd2; 4'd12: off = 3'd4;
      default: off = 3'd0;
    endcase
    return off;
  endfunction

  // Jan/Feb count as months of the previous year
  function automatic logic [WD_W-1:0] weekday_of(input logic [DAY_W-1:0] day,
                                                 input logic [MON_W-1:0] month,
                                                 input logic [15:0]      year);
    logic [15:0] y;
    logic [15:0] s;
    y = (month < 4'd3) ? year - 16'd1 : year;
    s = y + y / 16'd4 - y / 16'd100 + y / 16'd400 + 16'(sakamoto_off(month)) + 16'(day);
    return 3'(s % 16'd7);
  endfunction

  function automatic logic [23:0] weekday_ascii(input logic [WD_W-1:0] wd);
    logic [23:0] name;
    case (wd)
      3'd0: name = "SUN";
      3'd1: name = "MON";
      3'd2: name = "TUE";
      3'd3: name = "WED";
      3'd4: name = "THU";
      3'd5: name = "FRI";
      3'd6: name = "SAT";
      default: name = "???";
    endcase
    return name;
  endfunction

endpackage

// File: rtl/weekday_calc.sv
// Combinational weekday of a full date; the caller owns the register stage.
module weekday_calc
  import clock_pkg::*;
#(
  parameter int unsigned YW = 14
) (
  input  logic [DAY_W-1:0] i_day,
  input  logic [MON_W-1:0] i_month,
  input  logic [YW-1:0]    i_year,
  output logic [WD_W-1:0]  o_weekday_c
);

  assign o_weekday_c = weekday_of(i_day, i_month, 16'(i_year));

endmodule

// File: rtl/calendar_counter.sv
// Gregorian day/month/year counter with tick, field edit and bulk load,
// BCD date output and a registered weekday recomputed from the full date.
module calendar_counter
  import clock_pkg::*;
#(
  parameter int unsigned YEAR_MIN  = 2000,
  parameter int unsigned YEAR_MAX  = 2099,
  parameter int unsigned YW        = 14,
  parameter int unsigned RST_DAY   = 1,
  parameter int unsigned RST_MONTH = 1,
  parameter int unsigned RST_YEAR  = 2000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_fwd,
  input  logic          tick_back,
  input  logic          edit_en,
  input  logic [1:0]    edit_field,
  input  logic          edit_inc,
  input  logic          edit_dec,
  input  logic          load,
  input  logic [4:0]    load_day,
  input  logic [3:0]    load_month,
  input  logic [YW-1:0] load_year,
  output logic [31:0]   ddmmyyyy,
  output logic [2:0]    weekday,
  output logic [23:0]   weekascii,
  output logic          wd_valid,
  output logic          leap_year,
  output logic          year_wrap,
  output logic          load_err
);

  localparam logic [YW-1:0] Y_MIN = YW'(YEAR_MIN);
  localparam logic [YW-1:0] Y_MAX = YW'(YEAR_MAX);

  logic [DAY_W-1:0] r_day;
  logic [MON_W-1:0] r_month;
  logic [YW-1:0]    r_year;
  logic [WD_W-1:0]  r_weekday;
  logic             r_wd_valid, r_year_wrap, r_load_err;

  logic [DAY_W-1:0] w_day_nxt, w_mlen, w_prev_mlen, w_edit_mon_len, w_edit_yr_len;
  logic [MON_W-1:0] w_month_nxt, w_prev_month, w_edit_month;
  logic [YW-1:0]    w_year_nxt, w_edit_year;
  logic             w_wrap_nxt, w_err_nxt, w_leap, w_load_ok, w_edit_act, w_changed;
  logic [WD_W-1:0]  w_weekday_c;

  function automatic logic [7:0] bcd2(input logic [4:0] v);
    logic [3:0] tens;
    logic [4:0] units;
    if (v >= 5'd30)      begin tens = 4'd3; units = v - 5'd30; end
    else if (v >= 5'd20) begin tens = 4'd2; units = v - 5'd20; end
    else if (v >= 5'd10) begin tens = 4'd1; units = v - 5'd10; end
    else                 begin tens = 4'd0; units = v;         end
    return {tens, 4'(units)};
  endfunction

  // Double-dabble over four BCD digits
  function automatic logic [15:0] year_bcd(input logic [YW-1:0] y);
    logic [15:0] b;
    b = '0;
    for (int i = YW - 1; i >= 0; i--) begin
      for (int k = 0; k < 4; k++)
        if (b[4*k +: 4] >= 4'd5) b[4*k +: 4] = b[4*k +: 4] + 4'd3;
      b = {b[14:0], y[i]};
    end
    return b;
  endfunction

  assign w_leap       = is_leap(16'(r_year));
  assign w_mlen       = month_len(r_month, w_leap);
  assign w_prev_month = (r_month <= 4'd1) ? 4'd12 : r_month - 4'd1;
  assign w_prev_mlen  = month_len(w_prev_month, w_leap);

  assign w_edit_month   = edit_inc ? ((r_month >= 4'd12) ? 4'd1 : r_month + 4'd1)
                                   : ((r_month <= 4'd1) ? 4'd12 : r_month - 4'd1);
  assign w_edit_mon_len = month_len(w_edit_month, w_leap);
  assign w_edit_year    = edit_inc ? ((r_year >= Y_MAX) ? Y_MIN : r_year + YW'(1))
                                   : ((r_year <= Y_MIN) ? Y_MAX : r_year - YW'(1));
  assign w_edit_yr_len  = month_len(r_month, is_leap(16'(w_edit_year)));

  assign w_load_ok  = (load_year >= Y_MIN) && (load_year <= Y_MAX) && (load_day >= 5'd1) &&
                      (load_day <= month_len(load_month, is_leap(16'(load_year))));
  assign w_edit_act = edit_en && (edit_field != FIELD_NONE) && (edit_inc || edit_dec);

  // Next date: load beats edit beats ticks; losers are dropped
  always_comb begin
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    w_year_nxt  = r_year;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_day_nxt   = load_day;
        w_month_nxt = load_month;
        w_year_nxt  = load_year;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (w_edit_act) begin
      if (edit_inc != edit_dec) begin
        case (edit_field)
          FIELD_DAY: begin
            if (edit_inc) w_day_nxt = (r_day >= w_mlen) ? 5'd1 : r_day + 5'd1;
            else          w_day_nxt = (r_day <= 5'd1) ? w_mlen : r_day - 5'd1;
          end
          FIELD_MONTH: begin
            w_month_nxt = w_edit_month;
            w_day_nxt   = (r_day > w_edit_mon_len) ? w_edit_mon_len : r_day;
          end
          FIELD_YEAR: begin
            w_year_nxt = w_edit_year;
            w_day_nxt  = (r_day > w_edit_yr_len) ? w_edit_yr_len : r_day;
          end
          default: ;
        endcase
      end
    end else if (tick_fwd && !tick_back) begin
      if (r_day < w_mlen) begin
        w_day_nxt = r_day + 5'd1;
      end else begin
        w_day_nxt = 5'd1;
        if (r_month < 4'd12) begin
          w_month_nxt = r_month + 4'd1;
        end else begin
          w_month_nxt = 4'd1;
          if (r_year >= Y_MAX) begin
            w_year_nxt = Y_MIN;
            w_wrap_nxt = 1'b1;
          end else begin
            w_year_nxt = r_year + YW'(1);
          end
        end
      end
    end else if (tick_back && !tick_fwd) begin
      if (r_day > 5'd1) begin
        w_day_nxt = r_day - 5'd1;
      end else begin
        w_month_nxt = w_prev_month;
        w_day_nxt   = w_prev_mlen;
        if (r_month <= 4'd1) begin
          if (r_year <= Y_MIN) begin
            w_year_nxt = Y_MAX;
            w_wrap_nxt = 1'b1;
          end else begin
            w_year_nxt = r_year - YW'(1);
          end
        end
      end
    end
  end

  assign w_changed = (w_day_nxt != r_day) || (w_month_nxt != r_month) || (w_year_nxt != r_year);

  weekday_calc #(.YW(YW)) u_weekday_calc (
    .i_day       (r_day),
    .i_month     (r_month),
    .i_year      (r_year),
    .o_weekday_c (w_weekday_c)
  );

  // Weekday trails the date by one cycle; wd_valid flags that gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_day       <= DAY_W'(RST_DAY);
      r_month     <= MON_W'(RST_MONTH);
      r_year      <= YW'(RST_YEAR);
      r_weekday   <= weekday_of(DAY_W'(RST_DAY), MON_W'(RST_MONTH), 16'(RST_YEAR));
      r_wd_valid  <= 1'b1;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_weekday   <= w_weekday_c;
      r_wd_valid  <= !w_changed;
      r_year_wrap <= w_wrap_nxt;
      r_load_err  <= w_err_nxt;
    end
  end

  assign ddmmyyyy  = {bcd2(r_day), bcd2(5'(r_month)), year_bcd(r_year)};
  assign weekday   = r_weekday;
  assign weekascii = weekday_ascii(r_weekday);
  assign wd_valid  = r_wd_valid;
  assign leap_year = w_leap;
  assign year_wrap = r_year_wrap;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: a default-range instance and one
// with YEAR_MAX=2199 share stimulus; a negedge monitor checks queued expectations.
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_fwd, tick_back, edit_en, edit_inc, edit_dec, load;
  logic [1:0]  edit_field;
  logic [4:0]  load_day;
  logic [3:0]  load_month;
  logic [13:0] load_year;

  logic [31:0] dd1, dd2;
  logic [2:0]  wd1, wd2;
  logic [23:0] asc1, asc2;
  logic        wdv1, wdv2, leap1, leap2, wrap1, wrap2, err1, err2;

  always #5 clk = ~clk;

  calendar_counter u_dut (
    .clk(clk), .reset(reset), .tick_fwd(tick_fwd), .tick_back(tick_back),
    .edit_en(edit_en), .edit_field(edit_field), .edit_inc(edit_inc), .edit_dec(edit_dec),
    .load(load), .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .ddmmyyyy(dd1), .weekday(wd1), .weekascii(asc1), .wd_valid(wdv1),
    .leap_year(leap1), .year_wrap(wrap1), .load_err(err1)
  );

  calendar_counter #(.YEAR_MAX(2199)) u_dut2 (
    .clk(clk), .reset(reset), .tick_fwd(tick_fwd), .tick_back(tick_back),
    .edit_en(edit_en), .edit_field(edit_field), .edit_inc(edit_inc), .edit_dec(edit_dec),
    .load(load), .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .ddmmyyyy(dd2), .weekday(wd2), .weekascii(asc2), .wd_valid(wdv2),
    .leap_year(leap2), .year_wrap(wrap2), .load_err(err2)
  );

  typedef struct {
    int          cyc;
    bit          sel;
    bit          c_date;
    logic [31:0] dd;
    bit          leap;
    bit          wrap;
    bit          err;
    bit          c_wd;
    logic [2:0]  wd;
    bit          c_wdv;
    bit          wdv;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] asc_of(input logic [2:0] w);
    case (w)
      3'd0: return "SUN"; 3'd1: return "MON"; 3'd2: return "TUE"; 3'd3: return "WED";
      3'd4: return "THU"; 3'd5: return "FRI"; 3'd6: return "SAT";
      default: return "???";
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic check_entry(input exp_t e);
    logic [31:0] a_dd;
    logic [2:0]  a_wd;
    logic [23:0] a_asc;
    logic        a_wdv, a_leap, a_wrap, a_err;
    a_dd   = e.sel ? dd2   : dd1;
    a_wd   = e.sel ? wd2   : wd1;
    a_asc  = e.sel ? asc2  : asc1;
    a_wdv  = e.sel ? wdv2  : wdv1;
    a_leap = e.sel ? leap2 : leap1;
    a_wrap = e.sel ? wrap2 : wrap1;
    a_err  = e.sel ? err2  : err1;
    if (e.c_date) begin
      cmp({e.nm, " date"}, a_dd, e.dd);
      cmp({e.nm, " leap"}, 32'(a_leap), 32'(e.leap));
      cmp({e.nm, " wrap"}, 32'(a_wrap), 32'(e.wrap));
      cmp({e.nm, " err"},  32'(a_err),  32'(e.err));
    end
    if (e.c_wd) begin
      cmp({e.nm, " weekday"}, 32'(a_wd), 32'(e.wd));
      cmp({e.nm, " ascii"},   32'(a_asc), 32'(asc_of(e.wd)));
    end
    if (e.c_wdv) cmp({e.nm, " wd_valid"}, 32'(a_wdv), 32'(e.wdv));
  endtask

  // Monitor: check every expectation due in the current cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic clear_inputs();
    tick_fwd = 1'b0; tick_back = 1'b0; edit_en = 1'b0; edit_field = 2'd3;
    edit_inc = 1'b0; edit_dec = 1'b0; load = 1'b0;
    load_day = 5'd0; load_month = 4'd0; load_year = 14'd0;
  endtask

  task automatic set_load(input int d, input int m, input int y);
    load = 1'b1; load_day = 5'(d); load_month = 4'(m); load_year = 14'(y);
  endtask

  task automatic set_edit(input int field, input bit inc, input bit dec);
    edit_en = 1'b1; edit_field = 2'(field); edit_inc = inc; edit_dec = dec;
  endtask

  // Called at a negedge with inputs set; queues date/pulse and weekday expectations
  task automatic apply(input string nm, input bit sel, input logic [31:0] dd, input bit leap,
                       input bit wrap, input bit err, input bit changed, input logic [2:0] wd);
    exp_t e;
    e.sel = sel; e.c_date = 1'b1; e.dd = dd; e.leap = leap; e.nm = nm;
    e.cyc = cyc + 1; e.wrap = wrap; e.err = err; e.c_wd = 1'b0; e.wd = wd;
    e.c_wdv = 1'b1; e.wdv = !changed;
    sb.push_back(e);
    e.cyc = cyc + 2; e.wrap = 1'b0; e.err = 1'b0; e.c_wd = 1'b1; e.wdv = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    apply("reset idle", 0, 32'h01012000, 1, 0, 0, 0, 3'd6);

    set_load(28, 2, 2024); apply("ld 28feb24", 0, 32'h28022024, 1, 0, 0, 1, 3'd3);
    tick_fwd = 1'b1;       apply("fwd leapday", 0, 32'h29022024, 1, 0, 0, 1, 3'd4);
    tick_fwd = 1'b1;       apply("fwd 1mar24", 0, 32'h01032024, 1, 0, 0, 1, 3'd5);
    set_load(1, 3, 2000);  apply("ld 1mar00", 0, 32'h01032000, 1, 0, 0, 1, 3'd3);
    tick_back = 1'b1;      apply("back 29feb00", 0, 32'h29022000, 1, 0, 0, 1, 3'd2);

    set_load(28, 2, 2100); apply("ld 28feb2100", 1, 32'h28022100, 0, 0, 0, 1, 3'd0);
    tick_fwd = 1'b1;       apply("fwd 1mar2100", 1, 32'h01032100, 0, 0, 0, 1, 3'd1);
    set_load(31, 12, 2099); apply("ld2 31dec99", 1, 32'h31122099, 0, 0, 0, 1, 3'd4);
    tick_fwd = 1'b1;       apply("fwd 2100 nowrap", 1, 32'h01012100, 0, 0, 0, 1, 3'd5);

    set_load(31, 12, 2099); apply("ld 31dec99", 0, 32'h31122099, 0, 0, 0, 1, 3'd4);
    tick_fwd = 1'b1;       apply("fwd wrap", 0, 32'h01012000, 1, 1, 0, 1, 3'd6);
    tick_back = 1'b1;      apply("back wrap", 0, 32'h31122099, 0, 1, 0, 1, 3'd4);

    set_load(31, 1, 2023); apply("ld 31jan23", 0, 32'h31012023, 0, 0, 0, 1, 3'd2);
    set_edit(1, 1, 0);     apply("edit mon clamp", 0, 32'h28022023, 0, 0, 0, 1, 3'd2);
    set_edit(0, 1, 0); tick_fwd = 1'b1;
    apply("edit beats tick", 0, 32'h01022023, 0, 0, 0, 1, 3'd3);
    set_edit(0, 1, 1); tick_fwd = 1'b1;
    apply("inc+dec", 0, 32'h01022023, 0, 0, 0, 0, 3'd3);
    set_edit(0, 0, 1);     apply("edit day wrap", 0, 32'h28022023, 0, 0, 0, 1, 3'd2);
    set_edit(0, 1, 0); edit_en = 1'b0;
    apply("edit disabled", 0, 32'h28022023, 0, 0, 0, 0, 3'd2);
    set_edit(3, 1, 0); tick_fwd = 1'b1;
    apply("field none tick", 0, 32'h01032023, 0, 0, 0, 1, 3'd3);
    set_load(29, 2, 2000); apply("ld 29feb00", 0, 32'h29022000, 1, 0, 0, 1, 3'd2);
    set_edit(2, 0, 1);     apply("edit yr wrap", 0, 32'h28022099, 0, 0, 0, 1, 3'd6);
    set_edit(2, 1, 0);     apply("edit yr wrap up", 0, 32'h28022000, 1, 0, 0, 1, 3'd1);
    set_edit(1, 0, 1);     apply("edit mon dec", 0, 32'h28012000, 1, 0, 0, 1, 3'd5);

    set_load(15, 4, 2024); apply("ld 15apr24", 0, 32'h15042024, 1, 0, 0, 1, 3'd1);
    set_load(31, 4, 2024); apply("bad 31apr", 0, 32'h15042024, 1, 0, 1, 0, 3'd1);
    set_load(29, 2, 2023); apply("bad 29feb23", 0, 32'h15042024, 1, 0, 1, 0, 3'd1);
    set_load(1, 1, 1999);  apply("bad yr 1999", 0, 32'h15042024, 1, 0, 1, 0, 3'd1);
    set_load(1, 13, 2024); apply("bad mon 13", 0, 32'h15042024, 1, 0, 1, 0, 3'd1);
    set_load(0, 5, 2024);  apply("bad day 0", 0, 32'h15042024, 1, 0, 1, 0, 3'd1);
    set_load(30, 4, 2024); tick_fwd = 1'b1;
    apply("load beats tick", 0, 32'h30042024, 1, 0, 0, 1, 3'd2);
    tick_fwd = 1'b1; tick_back = 1'b1;
    apply("fwd+back", 0, 32'h30042024, 1, 0, 0, 0, 3'd2);
    tick_fwd = 1'b1;       apply("fwd 1may24", 0, 32'h01052024, 1, 0, 0, 1, 3'd3);
    set_load(31, 6, 2024); tick_fwd = 1'b1;
    apply("bad load drops tick", 0, 32'h01052024, 1, 0, 1, 0, 3'd3);

    // Asynchronous reset between clock edges, with a tick in flight
    tick_fwd = 1'b1;
    #2 reset = 1'b1;
    #1;
    cmp("async rst date", dd1, 32'h01012000);
    cmp("async rst weekday", 32'(wd1), 32'd6);
    cmp("async rst ascii", 32'(asc1), 32'(asc_of(3'd6)));
    cmp("async rst leap", 32'(leap1), 32'd1);
    cmp("async rst wd_valid", 32'(wdv1), 32'd1);
    @(negedge clk);
    cmp("rst holds over tick", dd1, 32'h01012000);
    cmp("rst wrap", 32'(wrap1), 32'd0);
    cmp("rst err", 32'(err1), 32'd0);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);

    // 2000 spaced ticks from reset; wd_valid low only in the cycle after each
    for (int n = 1; n < 2000; n++) begin
      tick_fwd = 1'b1;
      e.sel = 0; e.c_date = 0; e.c_wd = 0; e.c_wdv = 1; e.nm = "tick run";
      e.dd = '0; e.leap = 0; e.wrap = 0; e.err = 0; e.wd = '0;
      e.cyc = cyc + 1; e.wdv = 0; sb.push_back(e);
      e.cyc = cyc + 2; e.wdv = 1; sb.push_back(e);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
    end
    tick_fwd = 1'b1;
    apply("2000 ticks", 0, 32'h23062005, 0, 0, 0, 1, 3'd4);

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
